// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline-stage register.
package pipe_pkg;

   // Number of entries held by the stage, used directly as the FSM state.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } occ_state_t;

   // Default width of each perf-monitor counter.
   localparam int CNT_W_DEFAULT = 16;

endpackage : pipe_pkg

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter: counts inc cycles and sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] CNT_ONE = W'(1);
   localparam logic [W-1:0] CNT_MAX = '1;

   // Count up on inc, stop at the maximum value instead of wrapping.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != CNT_MAX)) begin
         cnt <= cnt + CNT_ONE;
      end
   end

endmodule : sat_counter

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline-stage register with a two-entry skid buffer,
// native flush/hold and saturating stall/bubble/flush perf counters.
// in_ready is a function of the skid flop, hold_in and flush only, so no
// combinational path runs from out_ready back to in_ready.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W        = 64,
   parameter int CLEAR_ON_KILL = 1,
   parameter int CNT_W         = CNT_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              hold_in,
   input  logic              flush,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   occ_state_t        state;
   logic [DATA_W-1:0] main_d;
   logic [DATA_W-1:0] skid_d;
   logic              main_v;
   logic              skid_v;
   logic              accept;
   logic              drain;
   logic              kill;

   // Entry valid bits are decoded from the registered state.
   assign main_v    = (state != ST_EMPTY);
   assign skid_v    = (state == ST_FULL);
   assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

   assign in_ready  = !skid_v && !hold_in && !flush;
   assign out_valid = main_v;
   assign out_data  = main_d;

   assign accept = in_valid && in_ready;
   assign drain  = out_valid && out_ready;

   // A flush only counts when something survives the same-cycle drain:
   // the skid entry always does, the main entry only if it is not taken.
   assign kill = flush && (skid_v || (main_v && !out_ready));

   // Occupancy FSM and payload registers; flush overrides every transition.
   // NOTE: payload flops are reset so out_data reads 0 straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_EMPTY;
         main_d <= '0;
         skid_d <= '0;
      end else if (flush) begin
         state <= ST_EMPTY;
         if (CLEAR_ON_KILL != 0) begin
            main_d <= '0;
            skid_d <= '0;
         end
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state  <= ST_ONE;
                  main_d <= in_data;
               end
            end
            ST_ONE: begin
               if (accept && drain) begin
                  main_d <= in_data;
               end else if (accept) begin
                  state  <= ST_FULL;
                  skid_d <= in_data;
               end else if (drain) begin
                  state <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (drain) begin
                  state  <= ST_ONE;
                  main_d <= skid_d;
               end
            end
            default: begin
               state <= ST_EMPTY;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (out_valid && !out_ready),
      .cnt   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hold_in && !flush),
      .cnt   (bubble_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (kill),
      .cnt   (flush_cnt)
   );

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a vector table, directed corner
// sequences and random traffic, all compared against a queue-based model.
// A second instance (CNT_W=4, CLEAR_ON_KILL=0) shares the same stimulus.
module tb_pipe_stage_skid;

   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          out_ready;
   logic          hold_in;
   logic          flush;

   logic          in_ready,  s_in_ready;
   logic          out_valid, s_out_valid;
   logic [DW-1:0] out_data,  s_out_data;
   logic [1:0]    occupancy, s_occupancy;
   logic [15:0]   stall_cnt, bubble_cnt, flush_cnt;
   logic [3:0]    s_stall_cnt, s_bubble_cnt, s_flush_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: FIFO contents plus unbounded event counts.
   logic [DW-1:0] mq[$];
   int m_stall, m_bubble, m_flush;

   typedef struct {
      logic          iv;
      logic [DW-1:0] id;
      logic          rdy;
      logic          e_valid;
      logic [DW-1:0] e_data;
      logic          e_ready;
      logic [1:0]    e_occ;
   } vec_t;

   vec_t tbl[17];

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(DW), .CLEAR_ON_KILL(1), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .hold_in(hold_in), .flush(flush),
      .occupancy(occupancy), .stall_cnt(stall_cnt),
      .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   pipe_stage_skid #(.DATA_W(DW), .CLEAR_ON_KILL(0), .CNT_W(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_data(s_out_data), .hold_in(hold_in), .flush(flush),
      .occupancy(s_occupancy), .stall_cnt(s_stall_cnt),
      .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
   );

   task automatic check(input string name, input logic [DW-1:0] act,
                        input logic [DW-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [DW-1:0] sat(input int v, input int w);
      int mx = (1 << w) - 1;
      return (v > mx) ? DW'(mx) : DW'(v);
   endfunction

   function automatic vec_t mk(input logic iv, input logic [DW-1:0] id,
                               input logic rdy, input logic ev,
                               input logic [DW-1:0] ed, input logic er,
                               input logic [1:0] eo);
      vec_t v;
      v.iv = iv; v.id = id; v.rdy = rdy;
      v.e_valid = ev; v.e_data = ed; v.e_ready = er; v.e_occ = eo;
      return v;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_stall = 0;
      m_bubble = 0;
      m_flush = 0;
   endtask

   // Drive one cycle's inputs, then compare both DUTs with the model at negedge.
   task automatic sample(input logic iv, input logic [DW-1:0] id,
                         input logic h, input logic f, input logic r);
      logic          e_valid;
      logic          e_ready;
      in_valid = iv; in_data = id; hold_in = h; flush = f; out_ready = r;
      @(negedge clk);
      e_valid = (mq.size() > 0);
      e_ready = (mq.size() < 2) && !h && !f;
      check("in_ready",    DW'(in_ready),    DW'(e_ready));
      check("s_in_ready",  DW'(s_in_ready),  DW'(e_ready));
      check("out_valid",   DW'(out_valid),   DW'(e_valid));
      check("s_out_valid", DW'(s_out_valid), DW'(e_valid));
      check("occupancy",   DW'(occupancy),   DW'(mq.size()));
      check("s_occupancy", DW'(s_occupancy), DW'(mq.size()));
      if (e_valid) begin
         check("out_data",   out_data,   mq[0]);
         check("s_out_data", s_out_data, mq[0]);
      end
      check("stall_cnt",    DW'(stall_cnt),    sat(m_stall, 16));
      check("bubble_cnt",   DW'(bubble_cnt),   sat(m_bubble, 16));
      check("flush_cnt",    DW'(flush_cnt),    sat(m_flush, 16));
      check("s_stall_cnt",  DW'(s_stall_cnt),  sat(m_stall, 4));
      check("s_bubble_cnt", DW'(s_bubble_cnt), sat(m_bubble, 4));
      check("s_flush_cnt",  DW'(s_flush_cnt),  sat(m_flush, 4));
   endtask

   // Apply the clock edge to the model, then move just past the DUT edge.
   task automatic advance();
      int occ = mq.size();
      bit drn = (occ > 0) && out_ready;
      bit acc = in_valid && (occ < 2) && !hold_in && !flush;
      if (occ > 0 && !out_ready) m_stall++;
      if (hold_in && !flush) m_bubble++;
      if (flush) begin
         if (occ - int'(drn) > 0) m_flush++;
         mq.delete();
      end else begin
         if (drn) void'(mq.pop_front());
         if (acc) mq.push_back(in_data);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input logic iv, input logic [DW-1:0] id,
                        input logic h, input logic f, input logic r);
      sample(iv, id, h, f, r);
      advance();
   endtask

   initial begin
      // Reset state
      rst_n = 1'b0;
      in_valid = 1'b0; in_data = '0; hold_in = 1'b0; flush = 1'b0; out_ready = 1'b0;
      model_reset();
      #8;
      check("rst out_valid", DW'(out_valid), '0);
      check("rst out_data",  out_data, '0);
      check("rst occupancy", DW'(occupancy), '0);
      check("rst in_ready",  DW'(in_ready), DW'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Streaming 1..8 then backpressure with 0x10/0x20
      for (int i = 0; i < 8; i++)
         tbl[i] = mk(1'b1, DW'(i + 1), 1'b1, (i != 0), DW'(i), 1'b1, (i != 0) ? 2'd1 : 2'd0);
      tbl[8]  = mk(1'b0, '0,        1'b1, 1'b1, 64'h8,  1'b1, 2'd1);
      tbl[9]  = mk(1'b0, '0,        1'b1, 1'b0, '0,     1'b1, 2'd0);
      tbl[10] = mk(1'b1, 64'h10,    1'b0, 1'b0, '0,     1'b1, 2'd0);
      tbl[11] = mk(1'b1, 64'h20,    1'b0, 1'b1, 64'h10, 1'b1, 2'd1);
      tbl[12] = mk(1'b0, '0,        1'b0, 1'b1, 64'h10, 1'b0, 2'd2);
      tbl[13] = mk(1'b0, '0,        1'b0, 1'b1, 64'h10, 1'b0, 2'd2);
      tbl[14] = mk(1'b0, '0,        1'b1, 1'b1, 64'h10, 1'b0, 2'd2);
      tbl[15] = mk(1'b0, '0,        1'b1, 1'b1, 64'h20, 1'b1, 2'd1);
      tbl[16] = mk(1'b0, '0,        1'b1, 1'b0, '0,     1'b1, 2'd0);
      for (int i = 0; i < 17; i++) begin
         sample(tbl[i].iv, tbl[i].id, 1'b0, 1'b0, tbl[i].rdy);
         check($sformatf("tbl[%0d] out_valid", i), DW'(out_valid), DW'(tbl[i].e_valid));
         check($sformatf("tbl[%0d] in_ready", i),  DW'(in_ready),  DW'(tbl[i].e_ready));
         check($sformatf("tbl[%0d] occupancy", i), DW'(occupancy), DW'(tbl[i].e_occ));
         if (tbl[i].e_valid)
            check($sformatf("tbl[%0d] out_data", i), out_data, tbl[i].e_data);
         advance();
      end
      check("backpressure stall_cnt", DW'(stall_cnt), DW'(3));

      // Flush while FULL with 0x30/0x40, a new beat offered during the flush
      cycle(1'b1, 64'h30, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 64'h40, 1'b0, 1'b0, 1'b0);
      sample(1'b1, 64'h99, 1'b0, 1'b1, 1'b0);
      check("flush in_ready", DW'(in_ready), '0);
      advance();
      sample(1'b1, 64'h60, 1'b0, 1'b0, 1'b1);
      check("post-flush out_valid", DW'(out_valid), '0);
      check("post-flush cleared out_data", out_data, '0);
      check("post-flush kept s_out_data", s_out_data, 64'h30);
      check("post-flush flush_cnt", DW'(flush_cnt), DW'(1));
      check("post-flush in_ready", DW'(in_ready), DW'(1));
      advance();
      sample(1'b0, '0, 1'b0, 1'b0, 1'b1);
      check("post-flush beat", out_data, 64'h60);
      advance();

      // Hold for two cycles with 0x55 offered, then release
      for (int i = 0; i < 2; i++) begin
         sample(1'b1, 64'h55, 1'b1, 1'b0, 1'b1);
         check("hold in_ready", DW'(in_ready), '0);
         check("hold bubble out_valid", DW'(out_valid), '0);
         advance();
      end
      sample(1'b1, 64'h55, 1'b0, 1'b0, 1'b1);
      check("hold bubble_cnt", DW'(bubble_cnt), DW'(2));
      advance();
      sample(1'b0, '0, 1'b0, 1'b0, 1'b1);
      check("hold release valid", DW'(out_valid), DW'(1));
      check("hold release data", out_data, 64'h55);
      advance();
      // Hold together with flush: no bubble counted
      cycle(1'b1, 64'h77, 1'b1, 1'b1, 1'b1);
      sample(1'b0, '0, 1'b0, 1'b0, 1'b1);
      check("hold+flush bubble_cnt", DW'(bubble_cnt), DW'(2));
      advance();

      // Asynchronous reset while FULL with 0xAA/0xBB
      cycle(1'b1, 64'hAA, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 64'hBB, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      check("pre-reset occupancy", DW'(occupancy), DW'(2));
      rst_n = 1'b0;
      #2;
      check("mid rst out_valid",  DW'(out_valid), '0);
      check("mid rst out_data",   out_data, '0);
      check("mid rst occupancy",  DW'(occupancy), '0);
      check("mid rst stall_cnt",  DW'(stall_cnt), '0);
      check("mid rst bubble_cnt", DW'(bubble_cnt), '0);
      check("mid rst flush_cnt",  DW'(flush_cnt), '0);
      check("mid rst in_ready",   DW'(in_ready), DW'(1));
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;

      // Counter saturation on the 4-bit instance
      cycle(1'b1, 64'h1, 1'b0, 1'b0, 1'b0);
      repeat (20) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      sample(1'b0, '0, 1'b0, 1'b0, 1'b1);
      check("sat s_stall_cnt", DW'(s_stall_cnt), DW'(15));
      check("sat stall_cnt",   DW'(stall_cnt),   DW'(20));
      advance();

      // Random traffic against the model
      for (int i = 0; i < 500; i++) begin
         cycle(1'($urandom_range(0, 1)), {$urandom, $urandom},
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 3) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_pipe_stage_skid

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, handshaked pipeline-stage register, successor to the fixed-field decode-to-execute flop. It carries an opaque DATA_W payload between any two pipeline stages using valid/ready flow control, with a two-entry skid buffer. The skid buffer gives full throughput with no combinational path from downstream ready to upstream ready. Flush (mispredict kill) and hold (bubble insertion) are native. Saturating stall, bubble and flush counters feed the perf-monitor.

## Interface
Parameters:
- DATA_W, 64: payload width (packed operands plus control fields, built by the instantiating stage).
- CLEAR_ON_KILL, 1: 1 = zero payload registers on flush; 0 = clear valid bits only.
- CNT_W, 16: width of each perf counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept; `!skid_v && !hold_in && !flush`.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream beat present (main entry valid).
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  main-entry payload, registered.
- hold_in  in  1  refuse new input this cycle (decode stall → bubble downstream).
- flush  in  1  kill all held entries and the offered beat (branch taken in EX).
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready.
- bubble_cnt  out  CNT_W  cycles with hold_in && !flush.
- flush_cnt  out  CNT_W  flush cycles that killed at least one valid entry.

## Operation
- Internal state: main entry (main_v, main_d) and skid entry (skid_v, skid_d). States are EMPTY, ONE and FULL.
- accept = in_valid && in_ready. drain = out_valid && out_ready.
- EMPTY:
  - accept → ONE, main_d ← in_data.
- ONE:
  - accept && drain → ONE, main_d ← in_data.
  - accept && !drain → FULL, skid_d ← in_data.
  - !accept && drain → EMPTY.
- FULL:
  - in_ready = 0.
  - drain → ONE, main_d ← skid_d, skid_v ← 0.
- flush has priority over all transitions:
  - Next state is EMPTY.
  - The offered beat is dropped (in_ready is low, so no handshake occurs).
  - If CLEAR_ON_KILL=1, main_d and skid_d ← 0.
  - A drain in the flush cycle still completes downstream; the flush applies to what remains.
- hold_in: blocks accept only. Held entries continue to drain, so downstream sees bubbles once the stage is empty.
- Ordering: strict FIFO; the skid entry is never presented before main.
- Counters:
  - Each counter increments by 1 on its condition and saturates at 2^CNT_W−1 (no wrap).
  - Counters are not cleared by flush.
- occupancy = main_v + skid_v.

## Timing
- Reset (rst_n low, asynchronous, takes effect immediately, including mid-transfer):
  - out_valid=0, out_data=0, skid cleared, occupancy=0, all counters 0.
  - in_ready reflects !hold_in && !flush while in reset release.
- Latency: beat accepted at edge N → out_valid=1 with that data after edge N (one cycle).
- Throughput: 1 beat/cycle sustained when out_ready=1.
- out_data is stable while out_valid && !out_ready.
- in_ready depends combinationally on hold_in and flush only; it never depends on out_ready.
- flush in cycle N → out_valid=0 after edge N; a new beat can be accepted in cycle N+1.
- Simultaneous flush and hold_in: flush behaviour applies; bubble_cnt does not increment.

## Structure
- Shared package pipe_pkg:
  - occupancy state encoding: ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - default CNT_W constant.
- One sub-module: sat_counter (parameter W; inputs clk, rst_n, inc; output cnt). It is instantiated three times.
- Payload field packing and unpacking belong to the instantiating stages, not this block.

## Test plan
- **Reset:** rst_n low mid-FULL with data 0xAA, 0xBB → next sample: out_valid=0, occupancy=0, counters 0, out_data=0.
- **Streaming:** DATA_W=64, out_ready=1, beats 1..8 on consecutive cycles → out_data 1..8 on consecutive cycles, each one cycle after acceptance, in_ready never low.
- **Backpressure:** out_ready=0 for 3 cycles while sending 0x10, 0x20 → occupancy 2, in_ready=0, stall_cnt=3. Release → 0x10 then 0x20 in order.
- **Flush:** flush while FULL with 0x30/0x40 offered → out_valid=0 next cycle, 0x30/0x40 never appear, flush_cnt=1. With CLEAR_ON_KILL=1, out_data=0.
- **Hold:** hold_in for 2 cycles with in_valid=1 (0x55) → in_ready=0, two bubbles downstream, bubble_cnt=2. 0x55 is accepted on release.
- **Saturation:** CNT_W=4, out_ready=0 for 20 cycles → stall_cnt holds at 15.
